// File: rtl/sys_mng_drp_poller.sv
// Round-robin DRP poller: sweeps ADDR_LIST, captures per-channel values, arbitrates a host port.
// Optional DRP_RDY watchdog enabled by defining SYS_MNG_DRP_POLLER_TIMEOUT_EN.
module sys_mng_drp_poller #(
    parameter int unsigned       N_CH           = 12,
    parameter logic [N_CH*8-1:0] ADDR_LIST      = {8'h00, 8'h20, 8'h24, 8'h01, 8'h21, 8'h25,
                                                   8'h02, 8'h22, 8'h26, 8'h06, 8'h23, 8'h27},
    parameter int unsigned       GAP_CYCLES     = 0,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic [7:0]         DRP_ADDR,
    output logic [15:0]        DRP_DI,
    input  logic [15:0]        DRP_DO,
    output logic               DRP_EN,
    output logic               DRP_WE,
    input  logic               DRP_RDY,
    output logic [N_CH*16-1:0] VALUES,
    output logic [N_CH-1:0]    UPDATED,
    output logic               SWEEP_DONE,
    input  logic               HOST_REQ,
    input  logic               HOST_WE,
    input  logic [7:0]         HOST_ADDR,
    input  logic [15:0]        HOST_DI,
    output logic               HOST_ACK,
    output logic [15:0]        HOST_DO,
    output logic               TIMEOUT_ERR
);

    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned CH_LAST  = N_CH - 1;

    if (N_CH < 1 || N_CH > 64) begin : g_bad_n_ch
        $error("sys_mng_drp_poller: N_CH must be 1..64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sys_mng_drp_poller: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                gap_pend_q, gap_pend_d;
    logic                xfer_host_q, xfer_host_d;
    logic                xfer_we_q, xfer_we_d;
    logic [7:0]          drp_addr_q, drp_addr_d;
    logic [15:0]         drp_di_q, drp_di_d;
    logic                drp_en_q, drp_en_d;
    logic                drp_we_q, drp_we_d;
    logic [15:0]         values_q [N_CH];
    logic [15:0]         values_d [N_CH];
    logic [N_CH-1:0]     updated_q, updated_d;
    logic                sweep_done_q, sweep_done_d;
    logic                host_ack_q, host_ack_d;
    logic [15:0]         host_do_q, host_do_d;
    logic                timeout_err_q, timeout_err_d;

    logic [7:0]          addr_tab [N_CH];
    logic                to_hit_c;
    logic                host_req_c;

    // Unpack the address list (channel 0 in the MS byte) and pack the value table likewise.
    for (genvar g = 0; g < N_CH; g++) begin : g_tab
        assign addr_tab[g] = ADDR_LIST[(N_CH-1-g)*8 +: 8];
        assign VALUES[(N_CH-1-g)*16 +: 16] = values_q[g];
    end

`ifdef SYS_MNG_DRP_POLLER_TIMEOUT_EN
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = TIMEOUT_CYCLES - 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        if (state_q == WAIT && !DRP_RDY) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    assign to_hit_c = (state_q == WAIT) && !DRP_RDY && (to_cnt_q == TO_W'(TO_LAST));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_hit_c = 1'b0;
`endif

    // The ACK cycle still sees the host's held request; it must not be granted twice.
    assign host_req_c = HOST_REQ && !host_ack_q;

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        gap_cnt_d     = gap_cnt_q;
        gap_pend_d    = gap_pend_q;
        xfer_host_d   = xfer_host_q;
        xfer_we_d     = xfer_we_q;
        drp_addr_d    = drp_addr_q;
        drp_di_d      = drp_di_q;
        drp_en_d      = 1'b0;
        drp_we_d      = 1'b0;
        values_d      = values_q;
        updated_d     = '0;
        sweep_done_d  = 1'b0;
        host_ack_d    = 1'b0;
        host_do_d     = host_do_q;
        timeout_err_d = timeout_err_q | to_hit_c;

        case (state_q)
            IDLE: state_d = ARB;
            ARB: begin
                if (host_req_c) begin
                    xfer_host_d = 1'b1;
                    xfer_we_d   = HOST_WE;
                    drp_addr_d  = HOST_ADDR;
                    drp_di_d    = HOST_DI;
                    drp_we_d    = HOST_WE;
                    drp_en_d    = 1'b1;
                    state_d     = ISSUE;
                end else if (gap_pend_q) begin
                    state_d = GAP;
                end else begin
                    xfer_host_d = 1'b0;
                    xfer_we_d   = 1'b0;
                    drp_addr_d  = addr_tab[ch_q];
                    drp_di_d    = '0;
                    drp_en_d    = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (DRP_RDY || to_hit_c) begin
                    if (xfer_host_q) begin
                        host_ack_d = 1'b1;
                        if (DRP_RDY && !xfer_we_q) begin
                            host_do_d = DRP_DO;
                        end
                        state_d = gap_pend_q ? GAP : ARB;
                    end else begin
                        if (DRP_RDY) begin
                            values_d[ch_q]  = DRP_DO;
                            updated_d[ch_q] = 1'b1;
                        end
                        if (ch_q == CH_W'(CH_LAST)) begin
                            ch_d         = '0;
                            sweep_done_d = DRP_RDY;
                            if (GAP_CYCLES > 0) begin
                                gap_pend_d = 1'b1;
                                state_d    = GAP;
                            end else begin
                                state_d = ARB;
                            end
                        end else begin
                            ch_d    = ch_q + 1'b1;
                            state_d = ARB;
                        end
                    end
                end
            end
            GAP: begin
                // A host request suspends the gap; the count resumes once the access is done.
                if (host_req_c) begin
                    state_d = ARB;
                end else if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    gap_cnt_d  = '0;
                    gap_pend_d = 1'b0;
                    state_d    = ARB;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            gap_cnt_q     <= '0;
            gap_pend_q    <= 1'b0;
            xfer_host_q   <= 1'b0;
            xfer_we_q     <= 1'b0;
            drp_addr_q    <= '0;
            drp_di_q      <= '0;
            drp_en_q      <= 1'b0;
            drp_we_q      <= 1'b0;
            values_q      <= '{default: '0};
            updated_q     <= '0;
            sweep_done_q  <= 1'b0;
            host_ack_q    <= 1'b0;
            host_do_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            gap_cnt_q     <= gap_cnt_d;
            gap_pend_q    <= gap_pend_d;
            xfer_host_q   <= xfer_host_d;
            xfer_we_q     <= xfer_we_d;
            drp_addr_q    <= drp_addr_d;
            drp_di_q      <= drp_di_d;
            drp_en_q      <= drp_en_d;
            drp_we_q      <= drp_we_d;
            values_q      <= values_d;
            updated_q     <= updated_d;
            sweep_done_q  <= sweep_done_d;
            host_ack_q    <= host_ack_d;
            host_do_q     <= host_do_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign DRP_ADDR    = drp_addr_q;
    assign DRP_DI      = drp_di_q;
    assign DRP_EN      = drp_en_q;
    assign DRP_WE      = drp_we_q;
    assign UPDATED     = updated_q;
    assign SWEEP_DONE  = sweep_done_q;
    assign HOST_ACK    = host_ack_q;
    assign HOST_DO     = host_do_q;
    assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: doc/sys_mng_drp_poller.md
Name: sys_mng_drp_poller

Overview:
- Parametrised successor of the fixed 12-register system-monitor DRP reader.
- Sweeps a configurable list of N_CH DRP addresses round-robin and holds the latest 16-bit value per channel.
- Adds a programmable inter-sweep gap, per-channel update strobes, a sweep-done pulse, and an arbitrated host read/write port sharing the same DRP.
- Sits between the SYSMON/XADC DRP port and system status/control logic.

Parameters:
- N_CH, 12, number of polled channels (1..64).
- ADDR_LIST, {8'h00,8'h20,8'h24,8'h01,8'h21,8'h25,8'h02,8'h22,8'h26,8'h06,8'h23,8'h27}, N_CH*8-bit packed DRP addresses; channel 0 occupies the MS byte.
- GAP_CYCLES, 0, idle cycles inserted after each full sweep (0 = back-to-back sweeps).
- TIMEOUT_CYCLES, 1024, DRP_RDY watchdog limit; used only with the optional feature.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high.
- DRP_ADDR  out  8  DRP address.
- DRP_DI  out  16  DRP write data.
- DRP_DO  in  16  DRP read data.
- DRP_EN  out  1  DRP enable, single-cycle pulse.
- DRP_WE  out  1  DRP write enable, valid with DRP_EN.
- DRP_RDY  in  1  DRP completion.
- VALUES  out  N_CH*16  latest value per channel; channel 0 occupies the MS word.
- UPDATED  out  N_CH  one-cycle pulse on the bit of the channel just captured.
- SWEEP_DONE  out  1  one-cycle pulse when the last channel is captured.
- HOST_REQ  in  1  host access request; level, held until HOST_ACK.
- HOST_WE  in  1  host write (1) or read (0).
- HOST_ADDR  in  8  host DRP address.
- HOST_DI  in  16  host write data.
- HOST_ACK  out  1  one-cycle pulse when the host access completes.
- HOST_DO  out  16  host read data; valid with HOST_ACK, held afterwards.
- TIMEOUT_ERR  out  1  sticky watchdog flag; constant 0 without the optional feature.

Behaviour:
- All DRP outputs and status outputs are registered.
- Reset values are all-zero: DRP_* outputs, VALUES, UPDATED, SWEEP_DONE, HOST_ACK, HOST_DO, TIMEOUT_ERR. Channel index resets to 0, gap counter to 0, state to IDLE.
- FSM states: IDLE, ARB, ISSUE, WAIT, GAP.
  - IDLE -> ARB on the first cycle after reset.
  - ARB: if HOST_REQ, latch HOST_WE/ADDR/DI, mark the transfer as host, -> ISSUE. Otherwise latch ADDR_LIST[ch], WE=0, mark as poll, -> ISSUE. Host has priority but is only granted in ARB, never mid-transfer.
  - ISSUE: DRP_EN=1 for exactly this cycle. DRP_ADDR, DRP_WE and DRP_DI are driven with the latched values. -> WAIT.
  - WAIT: hold DRP_ADDR. DRP_EN=0, DRP_WE=0. On DRP_RDY:
    - Poll read: VALUES[ch] <= DRP_DO and UPDATED[ch] pulses next cycle. If ch==N_CH-1, SWEEP_DONE pulses in the same cycle, ch <= 0, and the FSM goes -> GAP (or -> ARB if GAP_CYCLES==0). Otherwise ch <= ch+1, -> ARB.
    - Host read: HOST_DO <= DRP_DO. Host write: HOST_DO unchanged. In both cases HOST_ACK pulses next cycle, ch is not advanced, -> ARB.
  - GAP: count GAP_CYCLES cycles, then -> ARB. If HOST_REQ is high during GAP, leave early to ARB; the gap counter is preserved and resumes after the host access.
- Minimum poll latency per channel is 3 cycles (ARB, ISSUE, WAIT with RDY one cycle after EN).
- DRP_RDY outside WAIT is ignored.
- Reset mid-transfer aborts immediately. VALUES are cleared and no ACK is issued.
- HOST_REQ deasserted before ACK: request is ignored unless already latched in ARB; a latched transfer completes and ACKs anyway.
- Index width is clog2(N_CH), minimum 1. The wrap compare uses N_CH-1, so there are no out-of-range indices for any N_CH.

Optional Feature:
- Macro SYS_MNG_DRP_POLLER_TIMEOUT_EN.
- Defined: a counter runs in WAIT. On reaching TIMEOUT_CYCLES without DRP_RDY:
  - TIMEOUT_ERR is set (sticky until RESET).
  - For a poll transfer, VALUES[ch] is retained, UPDATED does not pulse, and ch advances as normal.
  - For a host transfer, HOST_ACK pulses with HOST_DO unchanged.
  - FSM goes -> ARB.
- Not defined: WAIT waits forever and TIMEOUT_ERR is tied 0.

Test Plan:
- Default params, DRP model returns 16'h1000+addr 1 cycle after EN -> 12 sequential reads at addrs 00,20,24,01,...,27. VALUES channel 0 = 16'h1000, channel 11 = 16'h1027. UPDATED walks bits 0..11. SWEEP_DONE pulses once per 12 captures, then ch wraps to 0.
- GAP_CYCLES=5, N_CH=3 -> exactly 5 cycles with DRP_EN=0 between SWEEP_DONE and the next ISSUE at ADDR_LIST[0].
- HOST_REQ write (addr 8'h41, data 16'hBEEF) while a poll is in WAIT -> the poll completes first. Next DRP_EN has WE=1, ADDR=8'h41, DI=16'hBEEF. HOST_ACK follows RDY by 1 cycle. Polling then resumes at the next channel (not skipped).
- HOST_REQ read (addr 8'h00) during GAP, model returns 16'h5A5A -> HOST_DO=16'h5A5A with ACK. VALUES unchanged. Remaining gap cycles are honoured after the access.
- RESET asserted in WAIT with RDY arriving the same cycle -> all outputs 0 next cycle, no UPDATED/ACK pulse. First post-reset access is to ADDR_LIST[0].
- With SYS_MNG_DRP_POLLER_TIMEOUT_EN, TIMEOUT_CYCLES=16, RDY withheld on channel 2 -> after 16 WAIT cycles TIMEOUT_ERR=1, VALUES channel 2 keeps its old value, next EN at channel 3's address.
